frog_ride_ctrl: RTL and testbench

// - Consumer end of the river-surface detection flags (onfish3/onlog/onfish2/onbiglog/water).
// - Per frame, turns the flags into a horizontal carry velocity for the frog motion block.
// - Runs the drown/carried-off-screen death sequence, the life counter and the respawn request.
// - Sits between the surface detector and the frog position register; everything advances on frame_clk.

---
 rtl/frogger_pkg.sv | 17 +
 rtl/frog_ride_ctrl.sv | 175 +++++++++++++++++
 tb/tb_frog_ride_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared frogger types and screen/carry constants used by the river-side blocks.
`timescale 1ns/1ps
package frogger_pkg;

  typedef enum logic [2:0] {SAFE, RIDING, SINKING, DYING, RESPAWN, GAMEOVER} ride_state_t;

  localparam int SCREEN_W  = 640;
  localparam int FROG_W    = 16;
  localparam int X_MAX_DEF = SCREEN_W - FROG_W - 1;

  // Object movers use the same per-frame speeds so the frog stays glued to its platform.
  localparam int LOG_DX_DEF    = 1;
  localparam int BIGLOG_DX_DEF = 2;
  localparam int FISH3_DX_DEF  = -1;
  localparam int FISH2_DX_DEF  = -2;

endpackage

// File: rtl/frog_ride_ctrl.sv
// River ride controller: turns surface flags into frog carry, runs drowning/off-screen
// death, the life counter and the respawn request. Advances once per frame_clk.
//
// state    | meaning
// SAFE     | on land, no carry
// RIDING   | on a platform, carry applied
// SINKING  | over open water, grace frames counting
// DYING    | death animation running
// RESPAWN  | one-frame respawn pulse
// GAMEOVER | no lives left, waits for reset
`timescale 1ns/1ps
module frog_ride_ctrl
  import frogger_pkg::*;
#(
  parameter int LOG_DX       = LOG_DX_DEF,
  parameter int BIGLOG_DX    = BIGLOG_DX_DEF,
  parameter int FISH3_DX     = FISH3_DX_DEF,
  parameter int FISH2_DX     = FISH2_DX_DEF,
  parameter int WATER_GRACE  = 2,
  parameter int DEATH_FRAMES = 32,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int LIVES_INIT   = 3
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  input  logic              onfish3,
  input  logic              onlog,
  input  logic              onfish2,
  input  logic              onbiglog,
  input  logic              water,
  input  logic              stage2x,
  input  logic              hop_active,
  input  logic [9:0]        frogX,
  output logic signed [3:0] frog_dx,
  output logic              drift_en,
  output logic              dying,
  output logic [2:0]        anim_frame,
  output logic              respawn,
  output logic [1:0]        lives,
  output logic              game_over
);

  localparam int DW = $clog2(DEATH_FRAMES);
  localparam int WW = $clog2(WATER_GRACE + 1);

  localparam logic signed [3:0]  LOG_C      = 4'(LOG_DX);
  localparam logic signed [3:0]  BIGLOG_C   = 4'(BIGLOG_DX);
  localparam logic signed [3:0]  FISH3_C    = 4'(FISH3_DX);
  localparam logic signed [3:0]  FISH2_C    = 4'(FISH2_DX);
  localparam logic signed [10:0] X_LIM      = 11'(X_MAX);
  localparam logic [WW-1:0]      GRACE_LAST = WW'(WATER_GRACE - 1);
  localparam logic [DW-1:0]      DEATH_LAST = DW'(DEATH_FRAMES - 1);

  ride_state_t       state_q;
  logic [WW-1:0]     water_cnt_q;
  logic [DW-1:0]     death_cnt_q;
  logic [1:0]        lives_q;
  logic signed [3:0] frog_dx_q;
  logic              drift_en_q;
  logic              dying_q;
  logic [2:0]        anim_q;
  logic              respawn_q;
  logic              game_over_q;

  logic              platform_d;
  logic signed [3:0] carry_raw_d;
  logic signed [3:0] carry_d;
  logic signed [10:0] pos_d;
  logic              off_screen_d;
  logic [DW-1:0]     death_nxt_d;

  always_comb begin
    platform_d  = onfish3 | onlog | onfish2 | onbiglog;
    carry_raw_d = 4'sd0;
    if (onfish3)       carry_raw_d = FISH3_C;
    else if (onlog)    carry_raw_d = LOG_C;
    else if (onfish2)  carry_raw_d = FISH2_C;
    else if (onbiglog) carry_raw_d = BIGLOG_C;
    carry_d = stage2x ? (carry_raw_d <<< 1) : carry_raw_d;
    // Negative result or past the right edge both mean the platform carried the frog away.
    pos_d        = $signed({1'b0, frogX}) + $signed({{7{carry_d[3]}}, carry_d});
    off_screen_d = pos_d[10] || (pos_d > X_LIM);
    death_nxt_d  = death_cnt_q + 1'b1;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= SAFE;
      water_cnt_q <= '0;
      death_cnt_q <= '0;
      lives_q     <= 2'(LIVES_INIT);
      frog_dx_q   <= 4'sd0;
      drift_en_q  <= 1'b0;
      dying_q     <= 1'b0;
      anim_q      <= 3'd0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      case (state_q)
        SAFE, RIDING, SINKING: begin
          frog_dx_q  <= 4'sd0;
          drift_en_q <= 1'b0;
          if (hop_active) begin
            state_q <= state_q;
          end else if (platform_d && off_screen_d) begin
            state_q     <= DYING;
            dying_q     <= 1'b1;
            death_cnt_q <= '0;
            anim_q      <= 3'd0;
            water_cnt_q <= '0;
          end else if (platform_d) begin
            state_q     <= RIDING;
            drift_en_q  <= 1'b1;
            frog_dx_q   <= carry_d;
            water_cnt_q <= '0;
          end else if (water) begin
            if (water_cnt_q >= GRACE_LAST) begin
              state_q     <= DYING;
              dying_q     <= 1'b1;
              death_cnt_q <= '0;
              anim_q      <= 3'd0;
              water_cnt_q <= '0;
            end else begin
              state_q     <= SINKING;
              water_cnt_q <= water_cnt_q + 1'b1;
            end
          end else begin
            state_q     <= SAFE;
            water_cnt_q <= '0;
          end
        end
        DYING: begin
          if (death_cnt_q == DEATH_LAST) begin
            dying_q     <= 1'b0;
            anim_q      <= 3'd0;
            death_cnt_q <= '0;
            if (lives_q <= 2'd1) begin
              lives_q     <= 2'd0;
              game_over_q <= 1'b1;
              state_q     <= GAMEOVER;
            end else begin
              lives_q   <= lives_q - 2'd1;
              respawn_q <= 1'b1;
              state_q   <= RESPAWN;
            end
          end else begin
            death_cnt_q <= death_nxt_d;
            anim_q      <= death_nxt_d[DW-1 -: 3];
          end
        end
        RESPAWN: begin
          state_q     <= SAFE;
          water_cnt_q <= '0;
          death_cnt_q <= '0;
        end
        GAMEOVER: begin
          state_q <= GAMEOVER;
        end
        default: begin
          state_q <= SAFE;
        end
      endcase
    end
  end

  assign frog_dx    = frog_dx_q;
  assign drift_en   = drift_en_q;
  assign dying      = dying_q;
  assign anim_frame = anim_q;
  assign respawn    = respawn_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_frog_ride_ctrl.sv
// Directed bench for frog_ride_ctrl: carry selection, drowning, off-screen death,
// death animation, lives/game-over and asynchronous reset.
`timescale 1ns/1ps
module tb_frog_ride_ctrl;

  logic              frame_clk = 1'b0;
  logic              Reset_n   = 1'b0;
  logic              onfish3 = 1'b0, onlog = 1'b0, onfish2 = 1'b0, onbiglog = 1'b0;
  logic              water = 1'b0, stage2x = 1'b0, hop_active = 1'b0;
  logic [9:0]        frogX = 10'd100;
  logic signed [3:0] frog_dx;
  logic              drift_en, dying, respawn, game_over;
  logic [2:0]        anim_frame;
  logic [1:0]        lives;

  int checks = 0;
  int errors = 0;

  frog_ride_ctrl dut (
    .frame_clk (frame_clk), .Reset_n (Reset_n),
    .onfish3 (onfish3), .onlog (onlog), .onfish2 (onfish2), .onbiglog (onbiglog),
    .water (water), .stage2x (stage2x), .hop_active (hop_active), .frogX (frogX),
    .frog_dx (frog_dx), .drift_en (drift_en), .dying (dying), .anim_frame (anim_frame),
    .respawn (respawn), .lives (lives), .game_over (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic drive(input logic f3, lg, f2, bl, w, s2, hop, input logic [9:0] x);
    onfish3 = f3; onlog = lg; onfish2 = f2; onbiglog = bl;
    water = w; stage2x = s2; hop_active = hop; frogX = x;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 10'd100);
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if (frog_dx !== 4'sd0) begin errors++; $display("FAIL reset_dx: got %0d expected 0", frog_dx); end
    checks++;
    if (drift_en !== 1'b0) begin errors++; $display("FAIL reset_drift: got %b expected 0", drift_en); end
    checks++;
    if ({dying, respawn, game_over} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {dying, respawn, game_over});
    end
    checks++;
    if (anim_frame !== 3'd0) begin errors++; $display("FAIL reset_anim: got %0d expected 0", anim_frame); end
    checks++;
    if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    checks++;
  endtask

  task automatic test_carry();
    logic signed [3:0] exp_dx [5];
    do_reset();
    exp_dx[0] = 4'sd1; exp_dx[1] = -4'sd4; exp_dx[2] = -4'sd1; exp_dx[3] = 4'sd4; exp_dx[4] = -4'sd2;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, 1, 0, 0, 0, 0, 0, 10'd100);
        1: drive(0, 0, 1, 0, 0, 1, 0, 10'd100);
        2: drive(1, 1, 0, 0, 0, 0, 0, 10'd100);
        3: drive(0, 0, 0, 1, 1, 1, 0, 10'd100);
        default: drive(1, 0, 1, 1, 1, 1, 0, 10'd100);
      endcase
      step();
      if (drift_en !== 1'b1 || frog_dx !== exp_dx[i]) begin
        errors++;
        $display("FAIL carry_%0d: got drift=%b dx=%0d expected drift=1 dx=%0d", i, drift_en, frog_dx, exp_dx[i]);
      end
      checks++;
    end
    drive(0, 1, 0, 0, 0, 0, 1, 10'd100);
    step();
    if (drift_en !== 1'b0) begin errors++; $display("FAIL hop_suppress: got %b expected 0", drift_en); end
    checks++;
    drive(0, 0, 0, 0, 0, 0, 0, 10'd100);
    step();
    if (drift_en !== 1'b0 || frog_dx !== 4'sd0) begin
      errors++; $display("FAIL land: got drift=%b dx=%0d expected drift=0 dx=0", drift_en, frog_dx);
    end
    checks++;
  endtask

  task automatic test_water_recover();
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 10'd100);
    step();
    drive(0, 1, 0, 0, 0, 0, 0, 10'd100);
    step();
    if (dying !== 1'b0 || drift_en !== 1'b1) begin
      errors++; $display("FAIL water_recover: got dying=%b drift=%b expected dying=0 drift=1", dying, drift_en);
    end
    checks++;
    drive(0, 0, 0, 0, 1, 0, 0, 10'd100);
    step();
    if (dying !== 1'b0 || drift_en !== 1'b0) begin
      errors++; $display("FAIL water_one: got dying=%b drift=%b expected 0 0", dying, drift_en);
    end
    checks++;
    drive(0, 0, 0, 0, 1, 0, 1, 10'd100);
    step();
    if (dying !== 1'b0) begin errors++; $display("FAIL water_hop_hold: got %b expected 0", dying); end
    checks++;
    drive(0, 0, 0, 0, 1, 0, 0, 10'd100);
    step();
    if (dying !== 1'b1) begin errors++; $display("FAIL water_after_hop: got %b expected 1", dying); end
    checks++;
  endtask

  task automatic test_full_death();
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 10'd100);
    step();
    if (dying !== 1'b0) begin errors++; $display("FAIL drown_early: got %b expected 0", dying); end
    checks++;
    step();
    if (dying !== 1'b1 || drift_en !== 1'b0 || anim_frame !== 3'd0) begin
      errors++; $display("FAIL drown: got dying=%b drift=%b anim=%0d expected 1 0 0", dying, drift_en, anim_frame);
    end
    checks++;
    drive(0, 1, 0, 0, 0, 1, 1, 10'd1);
    for (int k = 1; k < 32; k++) begin
      step();
      if (dying !== 1'b1 || anim_frame !== 3'(k / 4) || respawn !== 1'b0) begin
        errors++;
        $display("FAIL dying_frame_%0d: got dying=%b anim=%0d respawn=%b expected 1 %0d 0", k, dying, anim_frame, respawn, k / 4);
      end
      checks++;
    end
    step();
    if (dying !== 1'b0 || respawn !== 1'b1 || lives !== 2'd2) begin
      errors++; $display("FAIL death_end: got dying=%b respawn=%b lives=%0d expected 0 1 2", dying, respawn, lives);
    end
    checks++;
    step();
    if (respawn !== 1'b0 || drift_en !== 1'b0 || lives !== 2'd2) begin
      errors++; $display("FAIL respawn_pulse: got respawn=%b drift=%b lives=%0d expected 0 0 2", respawn, drift_en, lives);
    end
    checks++;
    drive(0, 1, 0, 0, 0, 0, 0, 10'd100);
    step();
    if (drift_en !== 1'b1 || frog_dx !== 4'sd1 || dying !== 1'b0) begin
      errors++; $display("FAIL after_respawn: got drift=%b dx=%0d dying=%b expected 1 1 0", drift_en, frog_dx, dying);
    end
    checks++;
  endtask

  task automatic test_offscreen();
    do_reset();
    drive(0, 0, 0, 1, 0, 1, 0, 10'd619);
    step();
    if (drift_en !== 1'b1 || frog_dx !== 4'sd4 || dying !== 1'b0) begin
      errors++; $display("FAIL right_edge_ok: got drift=%b dx=%0d dying=%b expected 1 4 0", drift_en, frog_dx, dying);
    end
    checks++;
    drive(0, 0, 0, 1, 0, 1, 0, 10'd621);
    step();
    if (dying !== 1'b1 || drift_en !== 1'b0) begin
      errors++; $display("FAIL right_off: got dying=%b drift=%b expected 1 0", dying, drift_en);
    end
    checks++;
    do_reset();
    drive(0, 0, 1, 0, 0, 1, 0, 10'd4);
    step();
    if (drift_en !== 1'b1 || frog_dx !== -4'sd4 || dying !== 1'b0) begin
      errors++; $display("FAIL left_edge_ok: got drift=%b dx=%0d dying=%b expected 1 -4 0", drift_en, frog_dx, dying);
    end
    checks++;
    drive(0, 0, 1, 0, 0, 1, 0, 10'd1);
    step();
    if (dying !== 1'b1 || drift_en !== 1'b0) begin
      errors++; $display("FAIL left_off: got dying=%b drift=%b expected 1 0", dying, drift_en);
    end
    checks++;
  endtask

  task automatic test_game_over();
    logic [1:0] exp_lives;
    do_reset();
    for (int d = 1; d <= 3; d++) begin
      drive(0, 0, 1, 0, 0, 1, 0, 10'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 10'd100);
      repeat (31) step();
      if (dying !== 1'b1) begin errors++; $display("FAIL go_dying_%0d: got %b expected 1", d, dying); end
      checks++;
      step();
      exp_lives = 2'(3 - d);
      if (lives !== exp_lives || respawn !== (d < 3) || game_over !== (d == 3) || dying !== 1'b0) begin
        errors++;
        $display("FAIL go_end_%0d: got lives=%0d respawn=%b game_over=%b dying=%b expected lives=%0d", d, lives, respawn, game_over, dying, exp_lives);
      end
      checks++;
      step();
    end
    drive(0, 1, 0, 0, 1, 0, 0, 10'd100);
    repeat (40) begin
      step();
      if (game_over !== 1'b1 || lives !== 2'd0 || {respawn, dying, drift_en} !== 3'b000) begin
        errors++;
        $display("FAIL go_sticky: got go=%b lives=%0d respawn=%b dying=%b drift=%b", game_over, lives, respawn, dying, drift_en);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_dying();
    do_reset();
    drive(0, 0, 1, 0, 0, 1, 0, 10'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 10'd100);
    repeat (10) step();
    Reset_n = 1'b0;
    #1;
    if (dying !== 1'b0 || lives !== 2'd3 || anim_frame !== 3'd0 || respawn !== 1'b0) begin
      errors++; $display("FAIL reset_mid_dying: got dying=%b lives=%0d anim=%0d respawn=%b", dying, lives, anim_frame, respawn);
    end
    checks++;
    #1;
    Reset_n = 1'b1;
    repeat (30) begin
      step();
      if (respawn !== 1'b0 || dying !== 1'b0) begin
        errors++; $display("FAIL no_respawn_after_reset: got respawn=%b dying=%b expected 0 0", respawn, dying);
      end
      checks++;
    end
  endtask

  initial begin
    step();
    test_reset();
    test_carry();
    test_water_recover();
    test_full_death();
    test_offscreen();
    test_game_over();
    test_reset_mid_dying();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
